// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and busy-bit scoreboard in front of the register file write port.
// Optional macro WB_BYPASS_EN: lookups see a writeback accepted this cycle as already cleared.
module regfile_wb_sched #(
   parameter int REG_DATA_WIDTH_POW = 6,
   parameter int REG_MEM_DEPTH_POW  = 5
) (
   input  logic                                 clk_in,
   input  logic                                 reset_n_in,
   input  logic                                 req0_valid_in,
   input  logic [REG_MEM_DEPTH_POW-1:0]         req0_rd_in,
   input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]   req0_data_in,
   output logic                                 req0_ready_out,
   input  logic                                 req1_valid_in,
   input  logic [REG_MEM_DEPTH_POW-1:0]         req1_rd_in,
   input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]   req1_data_in,
   output logic                                 req1_ready_out,
   input  logic                                 issue_valid_in,
   input  logic [REG_MEM_DEPTH_POW-1:0]         issue_rd_in,
   input  logic [REG_MEM_DEPTH_POW-1:0]         rs1_in,
   input  logic [REG_MEM_DEPTH_POW-1:0]         rs2_in,
   output logic                                 rs1_busy_out,
   output logic                                 rs2_busy_out,
   output logic                                 rd_busy_out,
   output logic [REG_MEM_DEPTH_POW-1:0]         rd_out,
   output logic [(1<<REG_DATA_WIDTH_POW)-1:0]   data_write_out,
   output logic                                 write_en_out,
   output logic                                 waw_err_out
);

   localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
   localparam int REG_MEM_DEPTH  = 1 << REG_MEM_DEPTH_POW;
   localparam logic [REG_MEM_DEPTH-1:0] ONE_HOT0 = {{(REG_MEM_DEPTH-1){1'b0}}, 1'b1};

   logic                          r_rr;
   logic [REG_MEM_DEPTH-1:0]      r_busy;
   logic [REG_MEM_DEPTH_POW-1:0]  r_rd;
   logic [REG_DATA_WIDTH-1:0]     r_data;
   logic                          r_we;
   logic                          r_waw;

   logic                          w_gnt0;
   logic                          w_gnt1;
   logic                          w_xfer;
   logic [REG_MEM_DEPTH_POW-1:0]  w_wb_rd;
   logic [REG_DATA_WIDTH-1:0]     w_wb_data;
   logic                          w_wb_live;
   logic                          w_set;
   logic [REG_MEM_DEPTH-1:0]      w_set_vec;
   logic [REG_MEM_DEPTH-1:0]      w_clr_vec;
   logic [REG_MEM_DEPTH-1:0]      w_busy_raw;
   logic [REG_MEM_DEPTH-1:0]      w_busy_nxt;
   logic [REG_MEM_DEPTH-1:0]      w_view;
   logic                          w_waw;

   // Valid/ready: a writeback moves when valid and ready are both high at posedge;
   // ready is combinational and at most one requester is granted; rr breaks ties.
   assign w_gnt0 = req0_valid_in & (~req1_valid_in | ~r_rr);
   assign w_gnt1 = req1_valid_in & (~req0_valid_in |  r_rr);
   assign w_xfer = w_gnt0 | w_gnt1;

   assign w_wb_rd   = w_gnt0 ? req0_rd_in   : req1_rd_in;
   assign w_wb_data = w_gnt0 ? req0_data_in : req1_data_in;
   assign w_wb_live = w_xfer && (w_wb_rd != '0);

   assign w_set     = issue_valid_in && (issue_rd_in != '0);
   assign w_set_vec = w_set     ? (ONE_HOT0 << issue_rd_in) : '0;
   assign w_clr_vec = w_wb_live ? (ONE_HOT0 << w_wb_rd)     : '0;

   // A new producer issued on the same edge as the old one retires keeps the bit set.
   assign w_busy_raw = (r_busy & ~w_clr_vec) | w_set_vec;
   assign w_busy_nxt = {w_busy_raw[REG_MEM_DEPTH-1:1], 1'b0};

`ifdef WB_BYPASS_EN
   assign w_view = r_busy & ~(w_clr_vec & ~w_set_vec);
`else
   assign w_view = r_busy;
`endif

   // The retiring producer on this edge is not a WAW conflict.
   assign w_waw = w_set && r_busy[issue_rd_in] && !w_clr_vec[issue_rd_in];

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_rr   <= 1'b0;
         r_busy <= '0;
         r_rd   <= '0;
         r_data <= '0;
         r_we   <= 1'b0;
         r_waw  <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_waw) r_waw <= 1'b1;
         if (w_xfer) begin
            r_rr   <= w_gnt0;
            r_rd   <= w_wb_rd;
            r_data <= w_wb_data;
            r_we   <= w_wb_live;
         end else begin
            r_we   <= 1'b0;
         end
      end
   end

   assign req0_ready_out = w_gnt0;
   assign req1_ready_out = w_gnt1;
   assign rs1_busy_out   = w_view[rs1_in];
   assign rs2_busy_out   = w_view[rs2_in];
   assign rd_busy_out    = w_view[issue_rd_in];
   assign rd_out         = r_rd;
   assign data_write_out = r_data;
   assign write_en_out   = r_we;
   assign waw_err_out    = r_waw;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: per-cycle vector table plus hand-written
// sequences for mid-cycle reset and the same-cycle writeback bypass.
module tb_regfile_wb_sched;

   localparam int DW = 64;
   localparam int AW = 5;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk_in = 1'b0;
   logic          reset_n_in = 1'b0;
   logic          req0_valid_in = 1'b0;
   logic [AW-1:0] req0_rd_in = '0;
   logic [DW-1:0] req0_data_in = '0;
   logic          req0_ready_out;
   logic          req1_valid_in = 1'b0;
   logic [AW-1:0] req1_rd_in = '0;
   logic [DW-1:0] req1_data_in = '0;
   logic          req1_ready_out;
   logic          issue_valid_in = 1'b0;
   logic [AW-1:0] issue_rd_in = '0;
   logic [AW-1:0] rs1_in = '0;
   logic [AW-1:0] rs2_in = '0;
   logic          rs1_busy_out, rs2_busy_out, rd_busy_out;
   logic [AW-1:0] rd_out;
   logic [DW-1:0] data_write_out;
   logic          write_en_out;
   logic          waw_err_out;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_sched dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in),
      .req0_valid_in(req0_valid_in), .req0_rd_in(req0_rd_in),
      .req0_data_in(req0_data_in), .req0_ready_out(req0_ready_out),
      .req1_valid_in(req1_valid_in), .req1_rd_in(req1_rd_in),
      .req1_data_in(req1_data_in), .req1_ready_out(req1_ready_out),
      .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in),
      .rs1_busy_out(rs1_busy_out), .rs2_busy_out(rs2_busy_out),
      .rd_busy_out(rd_busy_out), .rd_out(rd_out),
      .data_write_out(data_write_out), .write_en_out(write_en_out),
      .waw_err_out(waw_err_out)
   );

   // clock
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic          rst;
      logic          r0v;  logic [AW-1:0] r0rd; logic [DW-1:0] r0d;
      logic          r1v;  logic [AW-1:0] r1rd; logic [DW-1:0] r1d;
      logic          iv;   logic [AW-1:0] ird;
      logic [AW-1:0] rs1;  logic [AW-1:0] rs2;
      logic          e_rdy0, e_rdy1, e_rs1b, e_rs2b, e_rdb;
      logic          e_we; logic chk_port; logic [AW-1:0] e_rd; logic [DW-1:0] e_data;
      logic          e_waw;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(
      input logic rst,
      input logic r0v, input logic [AW-1:0] r0rd, input logic [DW-1:0] r0d,
      input logic r1v, input logic [AW-1:0] r1rd, input logic [DW-1:0] r1d,
      input logic iv, input logic [AW-1:0] ird, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
      input logic e_rdy0, input logic e_rdy1, input logic e_rs1b, input logic e_rs2b, input logic e_rdb,
      input logic e_we, input logic chk_port, input logic [AW-1:0] e_rd, input logic [DW-1:0] e_data,
      input logic e_waw);
      vec_t v;
      v.rst = rst; v.r0v = r0v; v.r0rd = r0rd; v.r0d = r0d;
      v.r1v = r1v; v.r1rd = r1rd; v.r1d = r1d; v.iv = iv; v.ird = ird;
      v.rs1 = rs1; v.rs2 = rs2; v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1;
      v.e_rs1b = e_rs1b; v.e_rs2b = e_rs2b; v.e_rdb = e_rdb;
      v.e_we = e_we; v.chk_port = chk_port; v.e_rd = e_rd; v.e_data = e_data; v.e_waw = e_waw;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      req0_valid_in = v.r0v; req0_rd_in = v.r0rd; req0_data_in = v.r0d;
      req1_valid_in = v.r1v; req1_rd_in = v.r1rd; req1_data_in = v.r1d;
      issue_valid_in = v.iv; issue_rd_in = v.ird; rs1_in = v.rs1; rs2_in = v.rs2;
   endtask

   task automatic idle();
      req0_valid_in = 1'b0; req1_valid_in = 1'b0; issue_valid_in = 1'b0;
   endtask

   task automatic pulse_reset();
      reset_n_in = 1'b0;
      #1;
      reset_n_in = 1'b1;
   endtask

   initial begin
      // rst r0v r0rd r0d     r1v r1rd r1d    iv ird rs1 rs2 | rdy0 rdy1 rs1b rs2b rdb | we chk rd data  waw
      vecs[0]  = mk(0, 0,0,64'h0,   0,0,64'h0,   1,5, 5,0,  0,0,0,0,0,  0,1,0,64'h0,  0);
      vecs[1]  = mk(0, 0,0,64'h0,   0,0,64'h0,   0,5, 5,0,  0,0,1,0,1,  0,1,0,64'h0,  0);
      vecs[2]  = mk(0, 1,5,64'hAA,  0,0,64'h0,   0,0, 5,0,  1,0,!BYP,0,0, 1,1,5,64'hAA, 0);
      vecs[3]  = mk(0, 0,0,64'h0,   0,0,64'h0,   0,0, 5,0,  0,0,0,0,0,  0,1,5,64'hAA, 0);
      vecs[4]  = mk(1, 1,3,64'h33,  1,4,64'h44,  0,0, 0,0,  1,0,0,0,0,  1,1,3,64'h33, 0);
      vecs[5]  = mk(0, 1,3,64'h33,  1,4,64'h44,  0,0, 0,0,  0,1,0,0,0,  1,1,4,64'h44, 0);
      vecs[6]  = mk(0, 1,3,64'h33,  1,4,64'h44,  0,0, 0,0,  1,0,0,0,0,  1,1,3,64'h33, 0);
      vecs[7]  = mk(0, 0,0,64'h0,   1,0,64'hFF,  0,0, 3,4,  0,1,0,0,0,  0,0,0,64'h0,  0);
      vecs[8]  = mk(0, 1,7,64'h77,  0,0,64'h0,   1,7, 7,0,  1,0,0,0,0,  1,1,7,64'h77, 0);
      vecs[9]  = mk(0, 0,0,64'h0,   0,0,64'h0,   0,7, 7,0,  0,0,1,0,1,  0,1,7,64'h77, 0);
      vecs[10] = mk(0, 0,0,64'h0,   0,0,64'h0,   1,9, 0,9,  0,0,0,0,0,  0,1,7,64'h77, 0);
      vecs[11] = mk(0, 0,0,64'h0,   0,0,64'h0,   1,9, 0,9,  0,0,0,1,1,  0,1,7,64'h77, 1);
      vecs[12] = mk(0, 0,0,64'h0,   0,0,64'h0,   0,9, 9,9,  0,0,1,1,1,  0,1,7,64'h77, 1);

      // reset state
      #3;
      chk("rst_we", write_en_out, 0);
      chk("rst_rd", rd_out, 0);
      chk("rst_data", data_write_out, 0);
      chk("rst_waw", waw_err_out, 0);
      chk("rst_rdy0", req0_ready_out, 0);
      @(negedge clk_in);
      reset_n_in = 1'b1;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk_in);
         if (vecs[i].rst) pulse_reset();
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_rdy0", i), req0_ready_out, vecs[i].e_rdy0);
         chk($sformatf("v%0d_rdy1", i), req1_ready_out, vecs[i].e_rdy1);
         chk($sformatf("v%0d_rs1b", i), rs1_busy_out, vecs[i].e_rs1b);
         chk($sformatf("v%0d_rs2b", i), rs2_busy_out, vecs[i].e_rs2b);
         chk($sformatf("v%0d_rdb", i), rd_busy_out, vecs[i].e_rdb);
         @(posedge clk_in);
         #1;
         chk($sformatf("v%0d_we", i), write_en_out, vecs[i].e_we);
         if (vecs[i].chk_port) begin
            chk($sformatf("v%0d_rd", i), rd_out, vecs[i].e_rd);
            chk($sformatf("v%0d_data", i), data_write_out, vecs[i].e_data);
         end
         chk($sformatf("v%0d_waw", i), waw_err_out, vecs[i].e_waw);
      end

      // mid-cycle reset while a write is on the port and waw is set
      @(negedge clk_in);
      idle();
      req0_valid_in = 1'b1; req0_rd_in = 5'd20; req0_data_in = 64'h1234; rs2_in = 5'd9;
      @(posedge clk_in);
      #1;
      chk("pre_rst_we", write_en_out, 1);
      req0_valid_in = 1'b0;
      #2;
      reset_n_in = 1'b0;
      #1;
      chk("async_we", write_en_out, 0);
      chk("async_rd", rd_out, 0);
      chk("async_data", data_write_out, 0);
      chk("async_waw", waw_err_out, 0);
      chk("async_rs2b", rs2_busy_out, 0);
      @(negedge clk_in);
      reset_n_in = 1'b1;

      // bypass: set busy[12], then retire it with a simultaneous re-issue, then a plain retire
      issue_valid_in = 1'b1; issue_rd_in = 5'd12; rs2_in = 5'd12;
      @(posedge clk_in);
      #1;
      chk("byp_set_rs2b", rs2_busy_out, 1);
      @(negedge clk_in);
      req0_valid_in = 1'b1; req0_rd_in = 5'd12; req0_data_in = 64'hC0DE;
      #1;
      chk("byp_reissue_rdb", rd_busy_out, 1);
      chk("byp_reissue_rs2b", rs2_busy_out, 1);
      @(posedge clk_in);
      #1;
      chk("byp_reissue_waw", waw_err_out, 0);
      chk("byp_reissue_busy", rs2_busy_out, 1);
      chk("byp_reissue_we", write_en_out, 1);
      @(negedge clk_in);
      issue_valid_in = 1'b0;
      #1;
      chk("byp_same_cycle_rs2b", rs2_busy_out, !BYP);
      @(posedge clk_in);
      #1;
      chk("byp_after_rs2b", rs2_busy_out, 0);
      chk("byp_after_rd", rd_out, 12);
      chk("byp_after_data", data_write_out, 64'hC0DE);
      @(negedge clk_in);
      idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
